// File: rtl/cpu_tstate_sequencer.sv
// cpu_tstate_sequencer: T-state/phase sequencer with RDY stalls, prioritised interrupt entry via forced BRK and carry-over control bits
//
// Ports:
//   clk, rst        master clock, synchronous active-high reset
//   rdy             external ready; stalls read cycles only
//   int_req         interrupt request lines (index 0 = highest priority)
//   int_mask        per-source mask, honoured by level-sensitive sources only
//   opcode_in       opcode fetched at the end of T1
//   cur_last        decoder: current (opcode,T) is the final cycle
//   cur_rd          decoder: current cycle is a bus read
//   cur_carry       decoder: control bits carried into the next T2 phi1
//   nxt_ctrl        decoder: control word for the nxt_* state
//   cur_opcode/t/phase   registered sequencer state
//   nxt_opcode/t/phase   combinational next state fed to the decoder
//   int_mode, int_id     active interrupt sequence and its source (NUM_INT = reset)
//   ctrl            registered control word aligned with cur_*
//   sync            high during T1
//   int_ack         one-clk one-hot acknowledge at sequence completion
//   rst_all         one-clk pulse on the first clk after reset
//   seq_err         sticky T-state overrun flag
module cpu_tstate_sequencer #(
    parameter int                 CTRL_W     = 80,
    parameter int                 NUM_INT    = 3,
    parameter logic [NUM_INT-1:0] EDGE_MASK  = 3'b001,
    parameter int                 MAX_T      = 8,
    parameter logic [7:0]         BRK_OPCODE = 8'h00,
    localparam int                TW         = $clog2(MAX_T + 1),
    localparam int                IW         = $clog2(NUM_INT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic [NUM_INT-1:0] int_req,
    input  logic [NUM_INT-1:0] int_mask,
    input  logic [7:0]         opcode_in,
    input  logic               cur_last,
    input  logic               cur_rd,
    input  logic [CTRL_W-1:0]  cur_carry,
    input  logic [CTRL_W-1:0]  nxt_ctrl,
    output logic [7:0]         cur_opcode,
    output logic [TW-1:0]      cur_t,
    output logic               cur_phase,
    output logic [7:0]         nxt_opcode,
    output logic [TW-1:0]      nxt_t,
    output logic               nxt_phase,
    output logic               int_mode,
    output logic [IW-1:0]      int_id,
    output logic [CTRL_W-1:0]  ctrl,
    output logic               sync,
    output logic [NUM_INT-1:0] int_ack,
    output logic               rst_all,
    output logic               seq_err
);
    logic [7:0]         r_opcode;
    logic [TW-1:0]      r_t;
    logic               r_phase;
    logic               r_int_mode;
    logic [IW-1:0]      r_int_id;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [CTRL_W-1:0]  r_carry;
    logic [NUM_INT-1:0] r_ack;
    logic [NUM_INT-1:0] r_pend;
    logic [NUM_INT-1:0] r_req_d;
    logic               r_rst_d;
    logic               r_rst_all;
    logic               r_err;

    logic               w_stall;
    logic               w_go;
    logic               w_t1;
    logic               w_fin;
    logic               w_over;
    logic               w_take;
    logic               w_done;
    logic [7:0]         w_nxt_opcode;
    logic [TW-1:0]      w_nxt_t;
    logic               w_nxt_phase;
    logic [NUM_INT-1:0] w_rise;
    logic [NUM_INT-1:0] w_pend;
    logic [NUM_INT-1:0] w_ack;
    logic [IW-1:0]      w_sel_id;
    logic [CTRL_W-1:0]  w_ctrl;

    // Edge sources ignore the mask; level sources are never latched.
    always_comb begin
        w_rise = int_req & ~r_req_d & EDGE_MASK;
        w_pend = (r_pend & EDGE_MASK) | (int_req & ~int_mask & ~EDGE_MASK);
        w_sel_id = '0;
        for (int i = NUM_INT - 1; i >= 0; i--)
            if (w_pend[i]) w_sel_id = IW'(i);
    end

    // Next-state logic. T1 is always the fetch cycle, so cur_last is not
    // treated as an instruction end while in T1.
    always_comb begin
        w_stall      = r_phase & ~rdy & cur_rd;
        w_go         = r_phase & ~w_stall;
        w_t1         = r_t == TW'(1);
        w_fin        = w_go & cur_last & ~w_t1;
        w_over       = w_go & ~cur_last & ~w_t1 & (r_t == TW'(MAX_T));
        w_nxt_phase  = ~r_phase;
        w_nxt_t      = !w_go ? r_t :
                       w_t1 ? TW'(2) :
                       (cur_last || r_t == TW'(MAX_T)) ? TW'(1) : r_t + TW'(1);
        w_nxt_opcode = (w_go & w_t1) ? (r_int_mode ? BRK_OPCODE : opcode_in) : r_opcode;
        w_take       = w_fin & ~r_int_mode & (|w_pend);
        w_done       = w_fin & r_int_mode;
        w_ack        = (w_done && r_int_id != IW'(NUM_INT)) ? NUM_INT'(1) << r_int_id : '0;
        // Carry bits only land on the T2 phi1 clk of the following instruction.
        w_ctrl       = nxt_ctrl | ((w_nxt_t == TW'(2) && !w_nxt_phase) ? r_carry : '0);
    end

    always_ff @(posedge clk) begin
        r_req_d <= int_req;
        r_rst_d <= rst;
        if (rst) begin
            r_opcode   <= BRK_OPCODE;
            r_t        <= TW'(2);
            r_phase    <= 1'b0;
            r_int_mode <= 1'b1;
            r_int_id   <= IW'(NUM_INT);
            r_ctrl     <= '0;
            r_carry    <= '0;
            r_ack      <= '0;
            r_pend     <= '0;
            r_rst_all  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_opcode   <= w_nxt_opcode;
            r_t        <= w_nxt_t;
            r_phase    <= w_nxt_phase;
            r_int_mode <= w_take | (r_int_mode & ~w_done);
            r_int_id   <= w_take ? w_sel_id : r_int_id;
            r_ctrl     <= w_ctrl;
            r_carry    <= w_fin ? cur_carry : (w_go & w_t1) ? '0 : r_carry;
            r_ack      <= w_ack;
            r_pend     <= (r_pend & ~w_ack) | w_rise;
            r_rst_all  <= r_rst_d;
            r_err      <= r_err | w_over;
        end
    end

    assign cur_opcode = r_opcode;
    assign cur_t      = r_t;
    assign cur_phase  = r_phase;
    assign nxt_opcode = w_nxt_opcode;
    assign nxt_t      = w_nxt_t;
    assign nxt_phase  = w_nxt_phase;
    assign int_mode   = r_int_mode;
    assign int_id     = r_int_id;
    assign ctrl       = r_ctrl;
    assign sync       = w_t1;
    assign int_ack    = r_ack;
    assign rst_all    = r_rst_all;
    assign seq_err    = r_err;
endmodule

// File: tb/tb_cpu_tstate_sequencer.sv
// tb_cpu_tstate_sequencer: directed table plus hand sequences for cpu_tstate_sequencer
module tb_cpu_tstate_sequencer;
    logic        clk;
    logic        rst;
    logic        rdy;
    logic [2:0]  int_req;
    logic [2:0]  int_mask;
    logic [7:0]  opcode_in;
    logic        cur_last;
    logic        cur_rd;
    logic [79:0] cur_carry;
    logic [79:0] nxt_ctrl;
    logic [7:0]  cur_opcode;
    logic [3:0]  cur_t;
    logic        cur_phase;
    logic [7:0]  nxt_opcode;
    logic [3:0]  nxt_t;
    logic        nxt_phase;
    logic        int_mode;
    logic [1:0]  int_id;
    logic [79:0] ctrl;
    logic        sync;
    logic [2:0]  int_ack;
    logic        rst_all;
    logic        seq_err;

    logic [3:0]  last_t;
    logic        rd;
    logic [79:0] carry_v;
    int          checks;
    int          errors;

    typedef struct {
        logic [3:0] last_t;
        logic [7:0] opc_in;
        logic [7:0] e_opc;
        logic [3:0] e_t;
        logic       e_ph;
        logic       e_mode;
        logic       e_sync;
        logic       e_rst_all;
    } vec_t;
    vec_t tbl [18];

    cpu_tstate_sequencer dut (
        .clk(clk), .rst(rst), .rdy(rdy), .int_req(int_req), .int_mask(int_mask),
        .opcode_in(opcode_in), .cur_last(cur_last), .cur_rd(cur_rd),
        .cur_carry(cur_carry), .nxt_ctrl(nxt_ctrl), .cur_opcode(cur_opcode),
        .cur_t(cur_t), .cur_phase(cur_phase), .nxt_opcode(nxt_opcode),
        .nxt_t(nxt_t), .nxt_phase(nxt_phase), .int_mode(int_mode),
        .int_id(int_id), .ctrl(ctrl), .sync(sync), .int_ack(int_ack),
        .rst_all(rst_all), .seq_err(seq_err)
    );

    function automatic logic [79:0] cw(input logic [7:0] o, input logic [3:0] t, input logic ph);
        return (80'(o) << 40) | (80'(t) << 20) | (80'(ph) << 16);
    endfunction

    // External decoder model: instruction ends at T = last_t (0 = never).
    assign cur_last  = (cur_t == last_t);
    assign cur_rd    = rd;
    assign cur_carry = carry_v;
    assign nxt_ctrl  = cw(nxt_opcode, nxt_t, nxt_phase);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic goto(input logic [3:0] t, input logic ph);
        int n;
        n = 0;
        while (!(cur_t == t && cur_phase == ph) && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL goto: got t%0d ph%0d expected t%0d ph%0d", cur_t, cur_phase, t, ph);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0]  = '{4'd7, 8'hA9, 8'h00, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{4'd7, 8'hA9, 8'h00, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'd7, 8'hA9, 8'h00, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{4'd7, 8'hA9, 8'h00, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{4'd7, 8'hA9, 8'h00, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{4'd7, 8'hA9, 8'h00, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{4'd7, 8'hA9, 8'h00, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{4'd7, 8'hA9, 8'h00, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{4'd7, 8'hA9, 8'h00, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{4'd7, 8'hA9, 8'h00, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{4'd7, 8'hA9, 8'h00, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{4'd7, 8'hA9, 8'h00, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{4'd7, 8'hA9, 8'h00, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{4'd2, 8'hA9, 8'hA9, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{4'd2, 8'hA9, 8'hA9, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{4'd2, 8'hA9, 8'hA9, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{4'd2, 8'hA9, 8'hA9, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{4'd2, 8'hEA, 8'hEA, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; rdy = 1'b1; rd = 1'b1; int_req = 3'b000; int_mask = 3'b000;
        opcode_in = 8'hA9; last_t = 4'd7; carry_v = '0;
        step();
        chk("rst_opcode", cur_opcode, 8'h00);
        chk("rst_t", cur_t, 4'd2);
        chk("rst_phase", cur_phase, 1'b0);
        chk("rst_mode", int_mode, 1'b1);
        chk("rst_id", int_id, 2'd3);
        chk("rst_ctrl", ctrl, '0);
        chk("rst_sync", sync, 1'b0);
        chk("rst_ack", int_ack, 3'b000);
        chk("rst_err", seq_err, 1'b0);
        chk("rst_rst_all", rst_all, 1'b0);
        rst = 1'b0;

        // Reset BRK sequence ending at T7, then a 2-cycle opcode.
        for (int i = 0; i < 18; i++) begin
            last_t = tbl[i].last_t;
            opcode_in = tbl[i].opc_in;
            step();
            chk("tbl_opcode", cur_opcode, tbl[i].e_opc);
            chk("tbl_t", cur_t, tbl[i].e_t);
            chk("tbl_phase", cur_phase, tbl[i].e_ph);
            chk("tbl_mode", int_mode, tbl[i].e_mode);
            chk("tbl_id", int_id, 2'd3);
            chk("tbl_sync", sync, tbl[i].e_sync);
            chk("tbl_rst_all", rst_all, tbl[i].e_rst_all);
            chk("tbl_ack", int_ack, 3'b000);
            chk("tbl_ctrl", ctrl, cw(tbl[i].e_opc, tbl[i].e_t, tbl[i].e_ph));
        end

        // RDY stall during a T3 read: three repeated machine cycles.
        last_t = 4'd4;
        goto(4'd3, 1'b0);
        rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("stall_t", cur_t, 4'd3);
            chk("stall_phase", cur_phase, 1'(k % 2 == 0));
        end
        rdy = 1'b1;
        step();
        chk("stall_rel_t", cur_t, 4'd3);
        step();
        chk("stall_adv_t", cur_t, 4'd4);

        // RDY low on a write cycle is ignored.
        goto(4'd3, 1'b0);
        rd = 1'b0; rdy = 1'b0;
        step();
        chk("wr_t_ph1", cur_t, 4'd3);
        step();
        chk("wr_t_adv", cur_t, 4'd4);
        chk("wr_phase", cur_phase, 1'b0);
        rd = 1'b1; rdy = 1'b1;

        // Priority: level sources 1,2 pending, edge on source 0 wins.
        goto(4'd2, 1'b0);
        chk("pri_mode0", int_mode, 1'b0);
        int_req = 3'b110;
        step();
        int_req = 3'b111;
        goto(4'd1, 1'b0);
        chk("pri_mode", int_mode, 1'b1);
        chk("pri_id0", int_id, 2'd0);
        chk("pri_op_hold", cur_opcode, 8'hEA);
        step(); step();
        chk("pri_brk", cur_opcode, 8'h00);
        chk("pri_brk_t", cur_t, 4'd2);
        goto(4'd4, 1'b1);
        step();
        chk("pri_ack0", int_ack, 3'b001);
        chk("pri_done_mode", int_mode, 1'b0);
        chk("pri_done_t", cur_t, 4'd1);
        step();
        chk("pri_ack_pulse", int_ack, 3'b000);
        step();
        chk("pri_between_op", cur_opcode, 8'hEA);
        chk("pri_between_mode", int_mode, 1'b0);
        goto(4'd1, 1'b0);
        chk("pri_mode1", int_mode, 1'b1);
        chk("pri_id1", int_id, 2'd1);
        int_req = 3'b000;
        step(); step();
        chk("pri_brk1", cur_opcode, 8'h00);
        goto(4'd4, 1'b1);
        step();
        chk("pri_ack1", int_ack, 3'b010);
        step();
        chk("pri_ack1_pulse", int_ack, 3'b000);

        // Masked level source is never taken until unmasked.
        int_req = 3'b100; int_mask = 3'b100;
        goto(4'd1, 1'b0);
        chk("mask_mode_a", int_mode, 1'b0);
        step(); step();
        chk("mask_op_a", cur_opcode, 8'hEA);
        goto(4'd1, 1'b0);
        chk("mask_mode_b", int_mode, 1'b0);
        int_mask = 3'b000;
        step(); step();
        chk("mask_op_b", cur_opcode, 8'hEA);
        goto(4'd1, 1'b0);
        chk("unmask_mode", int_mode, 1'b1);
        chk("unmask_id", int_id, 2'd2);
        int_req = 3'b000;
        step(); step();
        chk("unmask_brk", cur_opcode, 8'h00);
        goto(4'd4, 1'b1);
        step();
        chk("unmask_ack", int_ack, 3'b100);
        step();

        // Carry bit 5 on the final cycle shows only in the next T2 phi1.
        goto(4'd4, 1'b0);
        carry_v = 80'h20;
        step(); step();
        carry_v = '0;
        step();
        chk("carry_t1", ctrl, cw(8'hEA, 4'd1, 1'b1));
        step();
        chk("carry_t2p0", ctrl, cw(8'hEA, 4'd2, 1'b0) | 80'h20);
        step();
        chk("carry_t2p1", ctrl, cw(8'hEA, 4'd2, 1'b1));
        step();
        chk("carry_t3p0", ctrl, cw(8'hEA, 4'd3, 1'b0));

        // Overrun: decoder never signals the last cycle.
        last_t = 4'd0;
        goto(4'd8, 1'b1);
        chk("ovr_err_before", seq_err, 1'b0);
        step();
        chk("ovr_t", cur_t, 4'd1);
        chk("ovr_phase", cur_phase, 1'b0);
        chk("ovr_err", seq_err, 1'b1);
        goto(4'd2, 1'b0);
        chk("ovr_sticky", seq_err, 1'b1);
        chk("ovr_op", cur_opcode, 8'hEA);

        // Mid-instruction reset aborts and clears the flag.
        rst = 1'b1;
        step();
        chk("rst2_err", seq_err, 1'b0);
        chk("rst2_opcode", cur_opcode, 8'h00);
        chk("rst2_t", cur_t, 4'd2);
        chk("rst2_mode", int_mode, 1'b1);
        chk("rst2_id", int_id, 2'd3);
        chk("rst2_ack", int_ack, 3'b000);
        chk("rst2_ctrl", ctrl, '0);
        rst = 1'b0;
        last_t = 4'd7;
        step();
        chk("rst2_pulse", rst_all, 1'b1);
        chk("rst2_ctrl_load", ctrl, cw(8'h00, 4'd2, 1'b1));
        step();
        chk("rst2_pulse_end", rst_all, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
